// File: rtl/video_pkg.sv
// Shared video types for the text path: character-cell layout and geometry.
package video_pkg;

  typedef logic [3:0] color_channel_t;

  typedef struct packed {
    color_channel_t bg;
    color_channel_t fg;
    logic [7:0]     code;
  } char_cell_t;

  localparam int CELL_W    = 8;
  localparam int CELL_H    = 16;
  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;

  // row*80 + col built from shifts so no multiplier is inferred
  function automatic logic [11:0] cell_addr80(input logic [4:0] row, input logic [6:0] col);
    return {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
  endfunction

endpackage

// File: rtl/text_cursor_blink.sv
// Frame counter advanced on each falling edge of vsync; blink_on is the cursor phase.
module text_cursor_blink #(
  parameter int BLINK_BIT = 5
) (
  input  logic clk_pix,
  input  logic rst,
  input  logic vsync,
  output logic blink_on
);

  logic [5:0] frame_cnt;
  logic       vsync_prev;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      frame_cnt  <= '0;
      vsync_prev <= 1'b1;
    end else begin
      vsync_prev <= vsync;
      if (vsync_prev && !vsync)
        frame_cnt <= frame_cnt + 6'd1;
    end
  end

  assign blink_on = ~frame_cnt[BLINK_BIT];

endmodule

// File: rtl/text_tile_renderer.sv
// 80x30 character-cell renderer: char RAM -> font ROM -> pixel select -> palette index, 3-cycle latency.
module text_tile_renderer
  import video_pkg::*;
#(
  parameter int             COLS      = 80,
  parameter int             ROWS      = 30,
  parameter logic [3:0]     PAL_BASE  = 4'h0,
  parameter int             BLINK_BIT = 5
) (
  input  logic        clk_pix,
  input  logic        rst,
  input  logic [10:0] sx,
  input  logic [9:0]  sy,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [11:0] char_addr,
  input  logic [15:0] char_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [7:0]  palette_idx,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o
);

  logic [6:0] col_s0;
  logic [4:0] row_s0;

  logic [2:0] sx_s1;
  logic [3:0] sy_s1;
  logic [6:0] col_s1;
  logic [4:0] row_s1;
  logic       hs_s1, vs_s1, de_s1;
  char_cell_t cell_s1;

  logic [2:0]     sx_s2;
  logic [3:0]     sy_s2;
  logic [6:0]     col_s2;
  logic [4:0]     row_s2;
  logic           hs_s2, vs_s2, de_s2;
  color_channel_t fg_s2, bg_s2;

  logic blink_on;
  logic font_bit;
  logic cursor_hit;
  logic pix;

  logic unused_bits;
  assign unused_bits = ^{sx[10], sy[9], cell_s1.code[7]};

  assign col_s0 = sx[9:3];
  assign row_s0 = sy[8:4];

  generate
    if (COLS == 80) begin : g_addr80
      assign char_addr = cell_addr80(row_s0, col_s0);
    end else begin : g_addr_gen
      assign char_addr = 12'(int'(row_s0) * COLS + int'(col_s0));
    end
  endgenerate

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx_s1  <= '0;
      sy_s1  <= '0;
      col_s1 <= '0;
      row_s1 <= '0;
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
      de_s1  <= 1'b0;
    end else begin
      sx_s1  <= sx[2:0];
      sy_s1  <= sy[3:0];
      col_s1 <= col_s0;
      row_s1 <= row_s0;
      hs_s1  <= hsync;
      vs_s1  <= vsync;
      de_s1  <= de;
    end
  end

  assign cell_s1   = char_cell_t'(char_data);
  assign font_addr = {cell_s1.code[6:0], sy_s1};

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx_s2  <= '0;
      sy_s2  <= '0;
      col_s2 <= '0;
      row_s2 <= '0;
      hs_s2  <= 1'b1;
      vs_s2  <= 1'b1;
      de_s2  <= 1'b0;
      fg_s2  <= '0;
      bg_s2  <= '0;
    end else begin
      sx_s2  <= sx_s1;
      sy_s2  <= sy_s1;
      col_s2 <= col_s1;
      row_s2 <= row_s1;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
      de_s2  <= de_s1;
      fg_s2  <= cell_s1.fg;
      bg_s2  <= cell_s1.bg;
    end
  end

  text_cursor_blink #(
    .BLINK_BIT(BLINK_BIT)
  ) u_blink (
    .clk_pix  (clk_pix),
    .rst      (rst),
    .vsync    (vsync),
    .blink_on (blink_on)
  );

  // Underline occupies the bottom two pixel rows of the cursor cell
  always_comb begin
    font_bit   = font_data[3'd7 - sx_s2];
    cursor_hit = cursor_en && blink_on
                 && (col_s2 == cursor_col) && (row_s2 == cursor_row)
                 && (int'(col_s2) < COLS) && (int'(row_s2) < ROWS)
                 && (sy_s2[3:1] == 3'b111);
    pix        = font_bit ^ cursor_hit;
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      palette_idx <= 8'h00;
      hsync_o     <= 1'b1;
      vsync_o     <= 1'b1;
      de_o        <= 1'b0;
    end else begin
      palette_idx <= de_s2 ? {PAL_BASE, (pix ? fg_s2 : bg_s2)} : 8'h00;
      hsync_o     <= hs_s2;
      vsync_o     <= vs_s2;
      de_o        <= de_s2;
    end
  end

endmodule

// File: tb/tb_text_tile_renderer.sv
// Directed bench for text_tile_renderer with uniform 1-cycle char/font memory models.
module tb_text_tile_renderer;

  logic        clk_pix = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] sx = '0;
  logic [9:0]  sy = '0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        de = 1'b0;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_col = '0;
  logic [4:0]  cursor_row = '0;
  logic [11:0] char_addr;
  logic [15:0] char_data = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [7:0]  palette_idx;
  logic        hsync_o, vsync_o, de_o;

  logic [15:0] char_word = 16'h2A41;
  logic [7:0]  font_val  = 8'h81;
  logic [7:0]  exp_pal [8];

  int errors = 0;
  int checks = 0;

  text_tile_renderer dut (
    .clk_pix     (clk_pix),
    .rst         (rst),
    .sx          (sx),
    .sy          (sy),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .cursor_en   (cursor_en),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .char_addr   (char_addr),
    .char_data   (char_data),
    .font_addr   (font_addr),
    .font_data   (font_data),
    .palette_idx (palette_idx),
    .hsync_o     (hsync_o),
    .vsync_o     (vsync_o),
    .de_o        (de_o)
  );

  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix) begin
    char_data <= char_word;
    font_data <= font_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_pix);
      #1;
    end
  endtask

  task automatic px(input int x, input int y, input logic d);
    sx = 11'(x);
    sy = 10'(y);
    de = d;
  endtask

  initial begin
    exp_pal = '{8'h0A, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h0A};

    // reset state
    rst = 1'b1;
    tick(2);
    check("rst_pal", 32'(palette_idx), 32'h00);
    check("rst_de", 32'(de_o), 32'h0);
    check("rst_hs", 32'(hsync_o), 32'h1);
    check("rst_vs", 32'(vsync_o), 32'h1);
    check("rst_fcnt", 32'(dut.u_blink.frame_cnt), 32'd0);
    rst = 1'b0;

    // addressing
    px(0, 0, 1'b0);     #1; check("addr_0_0", 32'(char_addr), 32'd0);
    px(639, 479, 1'b0); #1; check("addr_639_479", 32'(char_addr), 32'd2399);
    px(8, 16, 1'b0);    #1; check("addr_8_16", 32'(char_addr), 32'd81);
    px(200, 100, 1'b0); #1; check("addr_200_100", 32'(char_addr), 32'd505);

    // pixel select sweep, fully pipelined
    for (int i = 0; i < 10; i++) begin
      if (i < 8) px(i, 0, 1'b1);
      else       px(0, 0, 1'b0);
      tick();
      if (i >= 2) begin
        check($sformatf("sweep_pal_%0d", i - 2), 32'(palette_idx), 32'(exp_pal[i - 2]));
        check($sformatf("sweep_de_%0d", i - 2), 32'(de_o), 32'h1);
      end
    end

    // single-pixel hsync/de pulse alignment
    px(3, 0, 1'b0);
    tick(3);
    hsync = 1'b0;
    px(3, 0, 1'b1);
    tick();
    hsync = 1'b1;
    px(3, 0, 1'b0);
    check("align_hs_c1", 32'(hsync_o), 32'h1);
    tick();
    check("align_hs_c2", 32'(hsync_o), 32'h1);
    check("align_de_c2", 32'(de_o), 32'h0);
    tick();
    check("align_hs_c3", 32'(hsync_o), 32'h0);
    check("align_de_c3", 32'(de_o), 32'h1);
    check("align_pal_c3", 32'(palette_idx), 32'h02);
    tick();
    check("align_hs_c4", 32'(hsync_o), 32'h1);
    check("align_de_c4", 32'(de_o), 32'h0);
    check("align_pal_c4", 32'(palette_idx), 32'h00);

    // de low blanks the index whatever the font says
    font_val = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("blank_pal_%0d", i), 32'(palette_idx), 32'h00);
    end

    // font address ignores code bit 7
    char_word = 16'h2AC1;
    px(40, 46, 1'b0);
    tick(2);
    check("font_addr", 32'(font_addr), 32'h41E);
    char_word = 16'h2A41;

    // cursor overlay at (5,2) with blank font
    font_val   = 8'h00;
    cursor_en  = 1'b1;
    cursor_col = 7'd5;
    cursor_row = 5'd2;
    px(40, 46, 1'b1); tick(3); check("cur_row46", 32'(palette_idx), 32'h0A);
    px(47, 47, 1'b1); tick(3); check("cur_row47", 32'(palette_idx), 32'h0A);
    px(40, 45, 1'b1); tick(3); check("cur_row45", 32'(palette_idx), 32'h02);
    px(48, 46, 1'b1); tick(3); check("cur_col6", 32'(palette_idx), 32'h02);
    cursor_en = 1'b0;
    px(40, 46, 1'b1); tick(3); check("cur_off", 32'(palette_idx), 32'h02);
    cursor_en = 1'b1;

    // 32 vsync falls put the cursor in its off phase
    px(0, 0, 1'b0);
    repeat (32) begin
      vsync = 1'b0; tick();
      vsync = 1'b1; tick();
    end
    check("fcnt_32", 32'(dut.u_blink.frame_cnt), 32'd32);
    px(40, 46, 1'b1); tick(3); check("cur_blink_off", 32'(palette_idx), 32'h02);

    // 32 more wraps the counter
    px(0, 0, 1'b0);
    repeat (32) begin
      vsync = 1'b0; tick();
      vsync = 1'b1; tick();
    end
    check("fcnt_wrap", 32'(dut.u_blink.frame_cnt), 32'd0);
    px(40, 46, 1'b1); tick(3); check("cur_blink_on", 32'(palette_idx), 32'h0A);

    // held-low vsync counts once
    px(0, 0, 1'b0);
    vsync = 1'b0; tick(10);
    vsync = 1'b1; tick();
    check("fcnt_held", 32'(dut.u_blink.frame_cnt), 32'd1);

    // reset mid-line, coincident with a vsync fall
    font_val = 8'h81;
    px(0, 0, 1'b1);
    tick(3);
    check("pre_rst_pal", 32'(palette_idx), 32'h0A);
    rst   = 1'b1;
    vsync = 1'b0;
    tick();
    check("mid_rst_de", 32'(de_o), 32'h0);
    check("mid_rst_pal", 32'(palette_idx), 32'h00);
    check("mid_rst_hs", 32'(hsync_o), 32'h1);
    check("mid_rst_vs", 32'(vsync_o), 32'h1);
    check("mid_rst_fcnt", 32'(dut.u_blink.frame_cnt), 32'd0);
    rst   = 1'b0;
    vsync = 1'b1;
    px(0, 0, 1'b1);
    tick(2);
    check("post_rst_de_c2", 32'(de_o), 32'h0);
    tick();
    check("post_rst_de_c3", 32'(de_o), 32'h1);
    check("post_rst_pal_c3", 32'(palette_idx), 32'h0A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
